csa_final_adder_pipe: RTL and testbench

- Carry-propagate stage directly downstream of the 3:2 compressor tree.
- Consumes the redundant pair (S, C) and produces the final binary sum S+C mod 2^BIT_LEN, plus the carry-out bit.
- The carry chain is split into SEG_LEN-bit segments, one segment per pipeline stage, to bound the critical path.
- Valid/ready handshake on both sides; per-stage valid bits with bubble collapsing.

---
 rtl/csa_final_adder_pipe_if.sv | 30 +++
 rtl/csa_final_adder_pipe.sv | 121 ++++++++++++
 tb/tb_csa_final_adder_pipe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_final_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : csa_final_adder_pipe_if
// Description : Upstream (S, C) and downstream (sum, cout) valid/ready
//               streams of the segmented carry-propagate adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface csa_final_adder_pipe_if #(
    parameter int BIT_LEN = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [BIT_LEN-1:0] S;
    logic [BIT_LEN-1:0] C;
    logic               out_valid;
    logic               out_ready;
    logic [BIT_LEN-1:0] sum;
    logic               cout;

    modport master (
        output in_valid, S, C, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, S, C, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/csa_final_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csa_final_adder_pipe
// Description : Resolves a redundant (S, C) pair into S+C, one SEG_LEN-bit
//               carry segment per pipeline stage, with bubble-collapsing flow.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_final_adder_pipe #(
    parameter int BIT_LEN = 16,
    parameter int SEG_LEN = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    csa_final_adder_pipe_if.slave     bus,
    output logic                      busy
);

    localparam int NUM_SEGS = BIT_LEN / SEG_LEN;
    // The last stage has no unresolved C bits left to carry.
    localparam int CV_DEPTH = (NUM_SEGS > 1) ? NUM_SEGS - 1 : 1;

    logic [NUM_SEGS-1:0] w_valid;
    logic [NUM_SEGS-1:0] w_cry;
    logic [NUM_SEGS-1:0] w_adv;
    logic [BIT_LEN-1:0]  w_acc [NUM_SEGS];
    logic [BIT_LEN-1:0]  w_cv  [CV_DEPTH];

    // Advance chain runs from the output back toward the input so an empty
    // stage always accepts, whatever is stalled further down.
    always_comb begin
        w_adv                = '0;
        w_adv[NUM_SEGS-1]    = bus.out_ready | ~w_valid[NUM_SEGS-1];
        for (int k = NUM_SEGS - 2; k >= 0; k--) begin
            w_adv[k] = ~w_valid[k] | w_adv[k+1];
        end
    end

    for (genvar j = 0; j < NUM_SEGS; j++) begin : g_stage
        logic [SEG_LEN-1:0] w_a;
        logic [SEG_LEN-1:0] w_b;
        logic               w_cin;
        logic               w_vin;
        logic [SEG_LEN:0]   w_seg;
        logic [BIT_LEN-1:0] w_acc_in;
        logic [BIT_LEN-1:0] w_acc_nxt;
        logic               r_vld;
        logic               r_cry;
        logic [BIT_LEN-1:0] r_acc;

        if (j == 0) begin : g_head
            assign w_vin    = bus.in_valid;
            assign w_acc_in = bus.S;
            assign w_a      = bus.S[SEG_LEN-1:0];
            assign w_b      = bus.C[SEG_LEN-1:0];
            assign w_cin    = 1'b0;
        end else begin : g_body
            assign w_vin    = w_valid[j-1];
            assign w_acc_in = w_acc[j-1];
            assign w_a      = w_acc[j-1][j*SEG_LEN +: SEG_LEN];
            assign w_b      = w_cv[j-1][j*SEG_LEN +: SEG_LEN];
            assign w_cin    = w_cry[j-1];
        end

        assign w_seg = {1'b0, w_a} + {1'b0, w_b} + {{SEG_LEN{1'b0}}, w_cin};

        // r_acc holds resolved low segments and still-raw S bits above them.
        always_comb begin
            w_acc_nxt                           = w_acc_in;
            w_acc_nxt[j*SEG_LEN +: SEG_LEN]     = w_seg[SEG_LEN-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_cry <= 1'b0;
                r_acc <= '0;
            end else if (w_adv[j]) begin
                r_vld <= w_vin;
                r_cry <= w_seg[SEG_LEN];
                r_acc <= w_acc_nxt;
            end
        end

        assign w_valid[j] = r_vld;
        assign w_cry[j]   = r_cry;
        assign w_acc[j]   = r_acc;

        if (j < NUM_SEGS - 1) begin : g_cvec
            logic [BIT_LEN-1:0] w_cv_in;
            logic [BIT_LEN-1:0] r_cv;

            if (j == 0) begin : g_cv_head
                assign w_cv_in = bus.C;
            end else begin : g_cv_body
                assign w_cv_in = w_cv[j-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cv <= '0;
                end else if (w_adv[j]) begin
                    r_cv <= w_cv_in;
                end
            end

            assign w_cv[j] = r_cv;
        end
    end

    if (NUM_SEGS == 1) begin : g_no_cv
        assign w_cv[0] = '0;
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = w_valid[NUM_SEGS-1];
    assign bus.sum       = w_acc[NUM_SEGS-1];
    assign bus.cout      = w_cry[NUM_SEGS-1];
    assign busy          = |w_valid;

endmodule
`default_nettype wire

// File: tb/tb_csa_final_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_final_adder_pipe
// Description : Directed and random stimulus for csa_final_adder_pipe with a
//               queue scoreboard of expected {cout, sum} beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_final_adder_pipe;
    localparam int BIT_LEN = 16;
    localparam int SEG_LEN = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    csa_final_adder_pipe_if #(.BIT_LEN(BIT_LEN)) bus ();

    csa_final_adder_pipe #(
        .BIT_LEN (BIT_LEN),
        .SEG_LEN (SEG_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    logic [BIT_LEN:0] sb[$];
    int n_vec  = 0;
    int n_fail = 0;
    int n_in   = 0;
    int n_out  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample handshakes after inputs settle, then advance one clock edge.
    task automatic cycle(output bit acc);
        logic [BIT_LEN:0] exp;
        #1;
        acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        if (acc) begin
            sb.push_back({1'b0, bus.S} + {1'b0, bus.C});
            n_in++;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_beat", 32'(bus.out_valid), 32'd0);
            end else begin
                exp = sb.pop_front();
                check("beat", 32'({bus.cout, bus.sum}), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag);
        bit a;
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            cycle(a);
            n++;
        end
        check({tag, "_reached"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic drain(output int n);
        bit a;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() > 0 && n < 50) begin
            cycle(a);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               a;
        int               n;
        int               k;
        int               in0;
        int               out0;
        logic [BIT_LEN-1:0] bp_s [6];
        logic [BIT_LEN-1:0] bp_c [6];
        logic [BIT_LEN-1:0] e0;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.S         = '0;
        bus.C         = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;

        // Single beat: output on the 4th edge, busy for 4 cycles
        bus.out_ready = 1'b1;
        bus.S         = 16'h00FF;
        bus.C         = 16'h0001;
        bus.in_valid  = 1'b1;
        cycle(a);
        check("single_accept", 32'(a), 32'd1);
        bus.in_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            check("single_busy",   32'(busy),          32'd1);
            check("single_ovalid", 32'(bus.out_valid), 32'(e == 4));
            if (e < 4) cycle(a);
        end
        check("single_sum",  32'(bus.sum),  32'h0100);
        check("single_cout", 32'(bus.cout), 32'd0);
        cycle(a);
        check("single_idle_busy", 32'(busy), 32'd0);

        // Full carry ripple across every segment
        bus.S        = 16'hFFFF;
        bus.C        = 16'h0001;
        bus.in_valid = 1'b1;
        cycle(a);
        bus.in_valid = 1'b0;
        wait_out("ripple");
        check("ripple_sum",  32'(bus.sum),  32'h0000);
        check("ripple_cout", 32'(bus.cout), 32'd1);
        drain(n);

        // Streaming: 100 back-to-back beats
        k = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.S        = 16'($urandom);
            bus.C        = 16'($urandom);
            bus.in_valid = 1'b1;
            cycle(a);
            if (a) k++;
        end
        check("stream_accepted", 32'(k), 32'd100);
        drain(n);
        check("stream_tail_cycles", 32'(n), 32'd4);

        // Backpressure: 6 beats offered against a stalled consumer
        for (int i = 0; i < 6; i++) begin
            bp_s[i] = 16'($urandom);
            bp_c[i] = 16'($urandom);
        end
        e0 = bp_s[0] + bp_c[0];
        bus.out_ready = 1'b0;
        k = 0;
        for (int t = 0; t < 8; t++) begin
            bus.in_valid = 1'b1;
            bus.S        = bp_s[k];
            bus.C        = bp_c[k];
            cycle(a);
            if (a) k++;
            if (t >= 3) begin
                check("bp_out_valid",  32'(bus.out_valid), 32'd1);
                check("bp_sum_stable", 32'(bus.sum),       32'(e0));
            end
        end
        check("bp_accepted", 32'(k), 32'd4);
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        n = 0;
        while (k < 6 && n < 20) begin
            bus.in_valid = 1'b1;
            bus.S        = bp_s[k];
            bus.C        = bp_c[k];
            cycle(a);
            if (a) k++;
            n++;
        end
        check("bp_all_accepted", 32'(k), 32'd6);
        drain(n);

        // Bubbles: random valid and ready for 1000 cycles
        in0  = n_in;
        out0 = n_out;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.S        = 16'($urandom);
        bus.C        = 16'($urandom);
        for (int t = 0; t < 1000; t++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle(a);
            if (a || bus.in_valid !== 1'b1) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.S        = 16'($urandom);
                bus.C        = 16'($urandom);
            end
        end
        drain(n);
        check("bubble_in_eq_out", 32'(n_in - in0), 32'(n_out - out0));

        // Reset mid-flight with 3 beats in the pipe
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.S        = 16'($urandom);
            bus.C        = 16'($urandom);
            cycle(a);
        end
        bus.in_valid = 1'b0;
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum",       32'(bus.sum),       32'd0);
        check("midrst_busy",      32'(busy),          32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int t = 0; t < 6; t++) begin
            check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
            cycle(a);
        end
        bus.S        = 16'h1234;
        bus.C        = 16'h4321;
        bus.in_valid = 1'b1;
        cycle(a);
        bus.in_valid = 1'b0;
        wait_out("post_rst");
        check("post_rst_sum", 32'(bus.sum), 32'h5555);
        drain(n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
